mem_a_seq: RTL and testbench

Sequencer for the systolic array's A-operand memory bank (transpose FIFOs plus skew FIFOs). It accepts a DIM×DIM A tile from an upstream producer one row at a time over a valid/ready handshake and writes each row into the bank by row index. It then enables the bank for exactly the cycles needed to stream every skewed column into the array, and signals completion. It sits between the host/DMA row source and the A memory, and owns that memory's `WrEn`, `Arow`, `Ain` and `en` pins.

---
 rtl/mem_a_pkg.sv | 26 ++
 rtl/mem_a_seq_counter.sv | 46 ++++
 rtl/mem_a_seq.sv | 183 ++++++++++++++++++
 tb/tb_mem_a_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_a_pkg.sv
// -----------------------------------------------------------------------------
// mem_a_pkg
// Shared definitions for the A-operand memory bank sequencer.
//   mem_a_state_t : sequencer state encoding (IDLE, LOAD, STREAM, DONE)
//   mem_a_state_name : printable state name, handy in debug views
// -----------------------------------------------------------------------------
package mem_a_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } mem_a_state_t;

  function automatic string mem_a_state_name(input mem_a_state_t s);
    case (s)
      IDLE:    return "IDLE";
      LOAD:    return "LOAD";
      STREAM:  return "STREAM";
      DONE:    return "DONE";
      default: return "????";
    endcase
  endfunction

endpackage

// File: rtl/mem_a_seq_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Clearable enable counter with a terminal-count flag.
//   clk   in  clock
//   rst_n in  asynchronous active-low reset (count -> 0)
//   clr   in  synchronous clear, wins over en
//   en    in  count enable; wraps naturally at 2**W
//   cnt   out current count
//   tc    out high while cnt == MAX
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == W'(MAX));

endmodule

// File: rtl/mem_a_seq.sv
// -----------------------------------------------------------------------------
// mem_a_seq
// Sequencer for the systolic array's A-operand memory bank. Accepts a DIM x DIM
// tile one row per valid/ready handshake, writes each row into the bank at its
// row index, then enables the bank for 2*DIM-1 cycles (DIM columns plus DIM-1
// cycles of skew drain) and pulses done.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a tile (only looked at in IDLE)
//   abort      in   synchronous abort back to IDLE, highest priority
//   row_valid  in   producer row valid
//   row_data   in   producer row, DIM signed elements of BITS_AB
//   row_ready  out  high throughout LOAD
//   mem_wr_en  out  bank WrEn, high on an accepted row
//   mem_row    out  bank Arow, row index of the accepted row
//   mem_ain    out  bank Ain, row_data passed through on an accepted row
//   mem_en     out  bank en, high throughout STREAM
//   stream_cnt out  cycle index within STREAM (0 .. 2*DIM-2)
//   busy       out  state != IDLE
//   done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_a_seq
  import mem_a_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                row_valid,
  input  logic signed [DIM-1:0][BITS_AB-1:0]  row_data,
  output logic                                row_ready,
  output logic                                mem_wr_en,
  output logic        [$clog2(DIM)-1:0]       mem_row,
  output logic signed [DIM-1:0][BITS_AB-1:0]  mem_ain,
  output logic                                mem_en,
  output logic        [$clog2(2*DIM)-1:0]     stream_cnt,
  output logic                                busy,
  output logic                                done
);

  localparam int ROW_W    = $clog2(DIM);
  localparam int STREAM_W = $clog2(2*DIM);
  localparam int ROW_MAX    = DIM - 1;
  localparam int STREAM_MAX = 2*DIM - 2;

  mem_a_state_t state_reg;
  mem_a_state_t state_next;

  logic [ROW_W-1:0]    row_cnt;
  logic                row_last;
  logic                row_clr;
  logic [STREAM_W-1:0] stream_cnt_q;
  logic                stream_last;
  logic                stream_clr;
  logic                stream_en;
  logic                row_accept;

  // Handshake: row_ready is exactly "in LOAD", so acceptance reduces to this.
  assign row_accept = (state_reg == LOAD) && row_valid;

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  // row_cnt is held at zero outside LOAD, so every LOAD starts from row 0 and
  // an abort leaves no stale index behind.
  assign row_clr = abort || (state_reg != LOAD);

  mod_counter #(
    .W   (ROW_W),
    .MAX (ROW_MAX)
  ) u_row_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (row_clr),
    .en    (row_accept),
    .cnt   (row_cnt),
    .tc    (row_last)
  );

  // stream_cnt is held at zero outside STREAM and is cleared on its final
  // cycle so that DONE and IDLE present zero rather than a one-past value.
  assign stream_en  = (state_reg == STREAM);
  assign stream_clr = abort || (state_reg != STREAM) || stream_last;

  mod_counter #(
    .W   (STREAM_W),
    .MAX (STREAM_MAX)
  ) u_stream_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stream_clr),
    .en    (stream_en),
    .cnt   (stream_cnt_q),
    .tc    (stream_last)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (row_accept && row_last) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (stream_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Abort overrides every transition, including the last LOAD acceptance
    // and start-in-IDLE.
    if (abort) begin
      state_next = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    row_ready = 1'b0;
    mem_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
      end
      LOAD: begin
        row_ready = 1'b1;
        busy      = 1'b1;
      end
      STREAM: begin
        mem_en = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Write pins are zero unless a row is actually being accepted, so the bank
  // never sees a spurious address or data value on gap cycles.
  assign mem_wr_en  = row_accept;
  assign mem_row    = row_accept ? row_cnt : '0;
  assign stream_cnt = stream_cnt_q;

  for (genvar gi = 0; gi < DIM; gi++) begin : g_ain
    assign mem_ain[gi] = row_accept ? row_data[gi] : '0;
  end

endmodule

// File: tb/tb_mem_a_seq.sv
module tb_mem_a_seq;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;

  logic                         clk;
  logic                         rst_n;
  logic                         start;
  logic                         abort;
  logic                         row_valid;
  logic [DIM-1:0][BITS_AB-1:0]  row_data;
  logic                         row_ready;
  logic                         mem_wr_en;
  logic [2:0]                   mem_row;
  logic [DIM-1:0][BITS_AB-1:0]  mem_ain;
  logic                         mem_en;
  logic [3:0]                   stream_cnt;
  logic                         busy;
  logic                         done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0;
  int done_cyc;

  mem_a_seq #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .row_valid  (row_valid),
    .row_data   (row_data),
    .row_ready  (row_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_row    (mem_row),
    .mem_ain    (mem_ain),
    .mem_en     (mem_en),
    .stream_cnt (stream_cnt),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] row_pat(input int r);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < DIM; j++) v[j*8 +: 8] = 8'(8*r + j);
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  row_ready,  0);
    chk({tag, "_wr_en"},  mem_wr_en,  0);
    chk({tag, "_row"},    mem_row,    0);
    chk({tag, "_ain"},    mem_ain,    0);
    chk({tag, "_en"},     mem_en,     0);
    chk({tag, "_scnt"},   stream_cnt, 0);
    chk({tag, "_busy"},   busy,       0);
    chk({tag, "_done"},   done,       0);
  endtask

  // Drives DIM rows; bp inserts two invalid cycles before every row but the
  // first (valid pattern 1,0,0,1,0,0,...). hold keeps start at 1 throughout.
  task automatic load_tile(input bit bp, input bit hold);
    for (int r = 0; r < DIM; r++) begin
      if (bp && r > 0) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          start = hold; row_valid = 1'b0; row_data = 64'hDEAD_BEEF_CAFE_F00D;
          #1;
          chk("gap_wr_en", mem_wr_en, 0);
          chk("gap_ready", row_ready, 1);
          chk("gap_row",   mem_row,   0);
          chk("gap_ain",   mem_ain,   0);
          chk("gap_en",    mem_en,    0);
        end
      end
      @(negedge clk);
      start = hold; row_valid = 1'b1; row_data = row_pat(r);
      #1;
      $display("load row %0d: wr_en=%0b row=%0d ain=%h", r, mem_wr_en, mem_row, mem_ain);
      chk("load_ready", row_ready, 1);
      chk("load_wr_en", mem_wr_en, 1);
      chk("load_row",   mem_row,   r);
      chk("load_ain",   mem_ain,   row_pat(r));
      chk("load_en",    mem_en,    0);
      chk("load_busy",  busy,      1);
    end
  endtask

  // Checks the STREAM/DONE/IDLE tail. abort_at >= 0 aborts at that stream_cnt.
  // pulse_start drives start during STREAM (k=3) and during DONE.
  task automatic stream_tile(input int abort_at, input bit pulse_start);
    for (int k = 0; k < 2*DIM-1; k++) begin
      @(negedge clk);
      row_valid = 1'b0; row_data = '0;
      if (pulse_start) start = (k == 3);
      #1;
      $display("stream k=%0d: en=%0b cnt=%0d done=%0b", k, mem_en, stream_cnt, done);
      chk("stream_en",    mem_en,     1);
      chk("stream_cnt",   stream_cnt, k);
      chk("stream_ready", row_ready,  0);
      chk("stream_wr_en", mem_wr_en,  0);
      chk("stream_done",  done,       0);
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("sabort_en",   mem_en,     0);
        chk("sabort_busy", busy,       0);
        chk("sabort_cnt",  stream_cnt, 0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk); #1;
          chk("sabort_nodone", done, 0);
          chk("sabort_noen",   mem_en, 0);
        end
        return;
      end
    end
    @(negedge clk);
    if (pulse_start) start = 1'b1;
    #1;
    done_cyc = cyc;
    $display("done cycle: done=%0b busy=%0b", done, busy);
    chk("done_pulse", done,       1);
    chk("done_busy",  busy,       1);
    chk("done_en",    mem_en,     0);
    chk("done_cnt",   stream_cnt, 0);
    @(negedge clk);
    if (pulse_start) start = 1'b0;
    #1;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; row_valid = 1'b0; row_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Full tile, no stalls
    @(negedge clk); start = 1'b1; t0 = cyc; #1;
    chk("start_idle_busy", busy, 0);
    load_tile(1'b0, 1'b0);
    stream_tile(-1, 1'b0);
    $display("full tile latency=%0d", done_cyc - t0);
    chk("latency_full", done_cyc - t0, 3*DIM);

    // Backpressure
    @(negedge clk); start = 1'b1; #1;
    load_tile(1'b1, 1'b0);
    stream_tile(-1, 1'b0);

    // Abort during LOAD after 3 rows
    @(negedge clk); start = 1'b1; #1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); start = 1'b0; row_valid = 1'b1; row_data = row_pat(r); #1;
      chk("pre_abort_row", mem_row, r);
    end
    @(negedge clk); row_valid = 1'b0; abort = 1'b1; #1;
    @(negedge clk); abort = 1'b0; #1;
    chk("labort_busy",  busy,      0);
    chk("labort_ready", row_ready, 0);
    @(negedge clk); #1;
    chk("labort_noen", mem_en, 0);
    // Restart after abort begins again at row 0
    @(negedge clk); start = 1'b1; t0 = cyc; #1;
    load_tile(1'b0, 1'b0);
    stream_tile(-1, 1'b0);
    chk("latency_after_abort", done_cyc - t0, 3*DIM);

    // Abort at stream_cnt = 5
    @(negedge clk); start = 1'b1; #1;
    load_tile(1'b0, 1'b0);
    stream_tile(5, 1'b0);

    // Ignored start during STREAM and DONE
    @(negedge clk); start = 1'b1; t0 = cyc; #1;
    load_tile(1'b0, 1'b0);
    stream_tile(-1, 1'b1);
    chk("latency_ign_start", done_cyc - t0, 3*DIM);
    @(negedge clk); #1;
    chk("ign_start_idle", busy, 0);

    // start + abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1; #1;
    @(negedge clk); start = 1'b0; abort = 1'b0; #1;
    chk("start_abort_idle", busy, 0);
    @(negedge clk); #1;
    chk("start_abort_idle2", busy, 0);

    // Back-to-back with start held high
    @(negedge clk); start = 1'b1; t0 = cyc; #1;
    load_tile(1'b0, 1'b1);
    stream_tile(-1, 1'b0);
    chk("latency_b2b_1", done_cyc - t0, 3*DIM);
    t0 = cyc;  // this IDLE cycle samples start again
    load_tile(1'b0, 1'b1);
    stream_tile(-1, 1'b0);
    chk("latency_b2b_2", done_cyc - t0, 3*DIM);
    @(negedge clk); start = 1'b0; abort = 1'b1; #1;
    chk("b2b_third_load", busy, 1);
    @(negedge clk); abort = 1'b0; #1;
    chk("b2b_abort_idle", busy, 0);

    // Asynchronous reset in the middle of STREAM
    @(negedge clk); start = 1'b1; #1;
    load_tile(1'b0, 1'b0);
    @(posedge clk); #2;
    row_valid = 1'b0; row_data = '0;
    chk("pre_rst_en", mem_en, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("idle_busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
